fourbit_ff_checker: RTL and testbench

- Synthesizable, self-checking response monitor for the 4-bit flip-flop family (posedge clock, asynchronous set, clock enable).
- Observes the D/S/CE stimulus driven into a flip-flop under test and the Q it returns.
- Maintains a cycle-accurate reference model of the flip-flop, compares it against Q on every clock, and keeps mismatch and check counters for on-board self-test and simulation scoreboarding.
- It is the receiving end of the stimulus path: the stimulus generator drives the flip-flop, and this block reads its response.

---
 rtl/fourbit_ff_chk_pkg.sv | 44 ++++
 rtl/fourbit_ff_checker_sat_counter.sv | 33 +++
 rtl/fourbit_ff_checker.sv | 155 +++++++++++++++
 tb/tb_fourbit_ff_checker.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fourbit_ff_chk_pkg.sv
// ---------------------------------------------------------------------------
// fourbit_ff_chk_pkg
// Shared definitions for the 4-bit flip-flop response checker:
//   - FSM state encoding (IDLE/SYNC/CHECK/FAIL)
//   - default data and counter widths
//   - model_next(): the reference flip-flop next-state function
//     (set has priority over clock enable). It is shared by the checker and
//     by the simulation scoreboard.
// ---------------------------------------------------------------------------
package fourbit_ff_chk_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 8;

    // model_next works on a fixed wide vector so one function serves any
    // WIDTH up to MODEL_W; callers zero-extend and truncate with casts.
    localparam int MODEL_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_CHECK = 2'd2,
        ST_FAIL  = 2'd3
    } chk_state_t;

    // Next value of the flip-flop: set wins over enable, else load, else hold.
    function automatic logic [MODEL_W-1:0] model_next(
        input logic               s,
        input logic               ce,
        input logic [MODEL_W-1:0] d,
        input logic [MODEL_W-1:0] prior
    );
        logic [MODEL_W-1:0] nxt;
        if (s) begin
            nxt = {MODEL_W{1'b1}};
        end else if (ce) begin
            nxt = d;
        end else begin
            nxt = prior;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fourbit_ff_checker_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous active-high reset. Counts once per
// clock while inc is high and sticks at all-ones instead of wrapping.
// Ports:
//   clk  in   clock
//   R    in   synchronous active-high reset (clears q)
//   inc  in   count enable
//   q    out  W-bit registered count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         R,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    // Count register: reset, saturating increment, or hold.
    always_ff @(posedge clk) begin
        if (R) begin
            q <= {W{1'b0}};
        end else if (inc && (q != CNT_MAX)) begin
            q <= q + W'(1'b1);
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/fourbit_ff_checker.sv
// ---------------------------------------------------------------------------
// fourbit_ff_checker
// Response monitor for a WIDTH-bit flip-flop with async set and clock enable.
// Keeps a cycle-accurate reference model (exp_q_r) of the flip-flop under
// test, compares the observed Q against it on every edge in CHECK, and keeps
// sticky/pulse error flags plus saturating check and error counters.
// Ports:
//   clk      in   clock shared with the flip-flop under test
//   R        in   synchronous active-high reset, highest priority
//   en       in   checking enable
//   D        in   data driven into the flip-flop under test
//   S        in   set driven into the flip-flop under test
//   CE       in   clock enable driven into the flip-flop under test
//   Q        in   observed flip-flop output
//   mismatch out  one-cycle pulse: previous compare failed
//   error    out  sticky mismatch flag, cleared only by R
//   err_cnt  out  saturating mismatch count
//   chk_cnt  out  saturating compare count
//   state    out  current FSM state (debug)
// ---------------------------------------------------------------------------
module fourbit_ff_checker
    import fourbit_ff_chk_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int CNT_W       = DEF_CNT_W,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             R,
    input  logic             en,
    input  logic [WIDTH-1:0] D,
    input  logic             S,
    input  logic             CE,
    input  logic [WIDTH-1:0] Q,
    output logic             mismatch,
    output logic             error,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [1:0]       state
);

    chk_state_t       state_r;
    chk_state_t       state_nxt_s;
    logic [WIDTH-1:0] exp_q_r;
    logic [WIDTH-1:0] exp_nxt_s;
    logic             mismatch_r;
    logic             mismatch_nxt_s;
    logic             error_r;
    logic             error_nxt_s;
    logic [WIDTH-1:0] cmp_s;
    logic             miss_s;
    logic             chk_inc_s;
    logic             err_inc_s;

    // Compare value and mismatch detect. S is asynchronous at the flip-flop,
    // so Q must already read all ones whenever S is high at the sample edge.
    always_comb begin
        cmp_s  = S ? {WIDTH{1'b1}} : exp_q_r;
        miss_s = (Q != cmp_s);
    end

    // Next-state, model update and counter-increment decode.
    always_comb begin
        state_nxt_s    = state_r;
        exp_nxt_s      = exp_q_r;
        mismatch_nxt_s = 1'b0;
        error_nxt_s    = error_r;
        chk_inc_s      = 1'b0;
        err_inc_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (en) begin
                    state_nxt_s = ST_SYNC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SYNC: begin
                // The flip-flop's real state is unknown here, so the model is
                // seeded with Q as the prior value instead of exp_q_r.
                exp_nxt_s = WIDTH'(model_next(S, CE, MODEL_W'(D), MODEL_W'(Q)));
                if (en) begin
                    state_nxt_s = ST_CHECK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                // The compare at this edge happens regardless of en; en only
                // decides where the FSM goes next.
                chk_inc_s      = 1'b1;
                err_inc_s      = miss_s;
                mismatch_nxt_s = miss_s;
                exp_nxt_s      = WIDTH'(model_next(S, CE, MODEL_W'(D), MODEL_W'(exp_q_r)));
                if (miss_s) begin
                    error_nxt_s = 1'b1;
                end else begin
                    error_nxt_s = error_r;
                end
                if (STOP_ON_ERR && miss_s) begin
                    state_nxt_s = ST_FAIL;
                end else if (en) begin
                    state_nxt_s = ST_CHECK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FAIL: begin
                // Everything frozen except the mismatch pulse, which drops.
                state_nxt_s = ST_FAIL;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, model and flag registers; R overrides every other input.
    always_ff @(posedge clk) begin
        if (R) begin
            state_r    <= ST_IDLE;
            exp_q_r    <= {WIDTH{1'b0}};
            mismatch_r <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            exp_q_r    <= exp_nxt_s;
            mismatch_r <= mismatch_nxt_s;
            error_r    <= error_nxt_s;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_err_cnt (
        .clk (clk),
        .R   (R),
        .inc (err_inc_s),
        .q   (err_cnt)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_chk_cnt (
        .clk (clk),
        .R   (R),
        .inc (chk_inc_s),
        .q   (chk_cnt)
    );

    assign mismatch = mismatch_r;
    assign error    = error_r;
    assign state    = state_r;

endmodule

// File: tb/tb_fourbit_ff_checker.sv
// ---------------------------------------------------------------------------
// tb_fourbit_ff_checker
// Three checkers (default, STOP_ON_ERR=1, CNT_W=3) watch one behavioural
// 4-bit flip-flop with async set and clock enable. A stuck-at-0 mask on Q
// injects faults. Every cycle the driver pushes each checker's expected
// outputs (from a behavioural model) into a per-checker queue; a monitor on
// the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_fourbit_ff_checker;
    import fourbit_ff_chk_pkg::*;

    logic       clk = 1'b0;
    logic       R, en, S, CE;
    logic [3:0] D, Q, stuck;
    logic [3:0] ff_q = 4'h0;

    always #5 clk = ~clk;

    // Flip-flop under test: async set, clock enable.
    always @(posedge clk or posedge S) begin
        if (S) ff_q <= 4'hF;
        else if (CE) ff_q <= D;
    end
    assign Q = ff_q & ~stuck;

    logic       mm0, mm1, mm2, er0, er1, er2;
    logic [7:0] ec0, cc0, ec1, cc1;
    logic [2:0] ec2, cc2;
    logic [1:0] st0, st1, st2;

    fourbit_ff_checker u0 (
        .clk(clk), .R(R), .en(en), .D(D), .S(S), .CE(CE), .Q(Q),
        .mismatch(mm0), .error(er0), .err_cnt(ec0), .chk_cnt(cc0), .state(st0));
    fourbit_ff_checker #(.STOP_ON_ERR(1'b1)) u1 (
        .clk(clk), .R(R), .en(en), .D(D), .S(S), .CE(CE), .Q(Q),
        .mismatch(mm1), .error(er1), .err_cnt(ec1), .chk_cnt(cc1), .state(st1));
    fourbit_ff_checker #(.CNT_W(3)) u2 (
        .clk(clk), .R(R), .en(en), .D(D), .S(S), .CE(CE), .Q(Q),
        .mismatch(mm2), .error(er2), .err_cnt(ec2), .chk_cnt(cc2), .state(st2));

    int a_mm[3], a_er[3], a_ec[3], a_cc[3], a_st[3];
    always_comb begin
        a_mm[0] = 32'(mm0); a_er[0] = 32'(er0); a_ec[0] = 32'(ec0); a_cc[0] = 32'(cc0); a_st[0] = 32'(st0);
        a_mm[1] = 32'(mm1); a_er[1] = 32'(er1); a_ec[1] = 32'(ec1); a_cc[1] = 32'(cc1); a_st[1] = 32'(st1);
        a_mm[2] = 32'(mm2); a_er[2] = 32'(er2); a_ec[2] = 32'(ec2); a_cc[2] = 32'(cc2); a_st[2] = 32'(st2);
    end

    // Behavioural view of one checker: phase 0 idle, 1 sync, 2 check, 3 fail.
    typedef struct {
        int         ph;
        logic [3:0] e;
        int         mm;
        int         er;
        int         ec;
        int         cc;
    } mdl_t;

    mdl_t m[3];
    mdl_t sbq[3][$];
    int   maxc[3];
    bit   stop[3];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int sat_inc(input int v, input int mx);
        return (v < mx) ? v + 1 : mx;
    endfunction

    function automatic mdl_t step(input mdl_t cur, input bit r, input bit en_i, input bit s,
                                  input bit ce, input logic [3:0] d, input logic [3:0] q,
                                  input int mx, input bit stp);
        mdl_t       n;
        logic [3:0] want;
        bit         miss;
        n = cur;
        n.mm = 0;
        if (r) begin
            n.ph = 0; n.e = 4'h0; n.er = 0; n.ec = 0; n.cc = 0;
        end else if (cur.ph == 0) begin
            n.ph = en_i ? 1 : 0;
        end else if (cur.ph == 1) begin
            n.e  = 4'(model_next(s, ce, 32'(d), 32'(q)));
            n.ph = en_i ? 2 : 0;
        end else if (cur.ph == 2) begin
            want = s ? 4'hF : cur.e;
            miss = (q !== want);
            n.cc = sat_inc(cur.cc, mx);
            if (miss) begin
                n.ec = sat_inc(cur.ec, mx);
                n.er = 1;
                n.mm = 1;
            end
            n.e  = 4'(model_next(s, ce, 32'(d), 32'(cur.e)));
            n.ph = (stp && miss) ? 3 : (en_i ? 2 : 0);
        end
        return n;
    endfunction

    // One clock: drive on the falling edge, predict, then return after the rise.
    task automatic cyc(input bit r_i, input bit en_i, input bit s_i, input bit ce_i,
                       input logic [3:0] d_i, input logic [3:0] stk_i);
        @(negedge clk);
        R = r_i; en = en_i; S = s_i; CE = ce_i; D = d_i; stuck = stk_i;
        #1;
        for (int k = 0; k < 3; k++) begin
            m[k] = step(m[k], r_i, en_i, s_i, ce_i, d_i, Q, maxc[k], stop[k]);
            sbq[k].push_back(m[k]);
        end
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compare every checker against its queued expectation.
    always @(negedge clk) begin
        mdl_t ex;
        for (int k = 0; k < 3; k++) begin
            if (sbq[k].size() > 0) begin
                ex = sbq[k].pop_front();
                chk($sformatf("u%0d.mismatch", k), a_mm[k], ex.mm);
                chk($sformatf("u%0d.error", k),    a_er[k], ex.er);
                chk($sformatf("u%0d.err_cnt", k),  a_ec[k], ex.ec);
                chk($sformatf("u%0d.chk_cnt", k),  a_cc[k], ex.cc);
                chk($sformatf("u%0d.state", k),    a_st[k], ex.ph);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        R = 1'b1; en = 1'b0; S = 1'b0; CE = 1'b0; D = 4'h0; stuck = 4'h0;
        maxc[0] = 255; maxc[1] = 255; maxc[2] = 7;
        stop[0] = 1'b0; stop[1] = 1'b1; stop[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m[k].ph = 0; m[k].e = 4'h0; m[k].mm = 0; m[k].er = 0; m[k].ec = 0; m[k].cc = 0;
        end

        // Reset held two cycles with en high, then first compare on 3rd edge.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        chk("rst_state", a_st[0], 0);
        chk("rst_chk_cnt", a_cc[0], 0);
        chk("rst_error", a_er[0], 0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'($urandom), 4'h0);
        chk("first_cmp_chk_cnt", a_cc[0], 1);

        // Clean run: 16 compares with D stepping 0..F.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'(i), 4'h0);
        chk("clean_chk_cnt", a_cc[0], 16);
        chk("clean_err_cnt", a_ec[0], 0);

        // Q bit 2 stuck-at-0 while D=F for three compares.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'hF, 4'h4);
        chk("fault_mismatch", a_mm[0], 1);
        chk("fault_err_cnt", a_ec[0], 3);
        chk("fault_error", a_er[0], 1);
        chk("stop_state", a_st[1], 3);
        chk("stop_err_cnt", a_ec[1], 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'hF, 4'h0);
        chk("fault_release_mismatch", a_mm[0], 0);

        // Set beats enable; afterwards the model holds all ones.
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0);
        chk("set_prio_mismatch", a_mm[0], 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 4'h0);
        chk("set_hold_mismatch", a_mm[0], 0);

        // Randomized traffic: en toggling, async set, occasional faults/resets.
        for (int i = 0; i < 300; i++) begin
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 7) != 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                4'($urandom), ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0);
        end

        // Saturation: 10 forced mismatches into the 3-bit counters.
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 4'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'hF, 4'h4);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'hF, 4'h4);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'hF, 4'h4);
        chk("sat_err_cnt", a_ec[2], 7);
        chk("sat_error", a_er[2], 1);
        chk("sat_wide_err_cnt", a_ec[0], 10);
        chk("sat_state", a_st[2], 2);

        // Reset mid-CHECK clears everything, pending compare discarded.
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 4'h4);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("abort_u%0d_outputs", k),
                a_mm[k] + a_er[k] + a_ec[k] + a_cc[k] + a_st[k], 0);
        end

        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk($sformatf("u%0d_queue_drained", k), sbq[k].size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
